// File: rtl/riscv_mdu_if.sv
// Request/result handshake bundle between the execute stage and the multiply/divide unit.
// master = issuing pipeline, slave = riscv_mdu.
interface riscv_mdu_if #(
    parameter int XLEN = 32
);
    logic            i_mdu_valid;
    logic            o_mdu_ready;
    logic [2:0]      i_mdu_op;
    logic [XLEN-1:0] i_mdu_a;
    logic [XLEN-1:0] i_mdu_b;
    logic            i_mdu_flush;
    logic            o_mdu_valid;
    logic            i_mdu_res_ready;
    logic [XLEN-1:0] o_mdu_result;
    logic            o_mdu_busy;

    modport master (
        output i_mdu_valid, i_mdu_op, i_mdu_a, i_mdu_b, i_mdu_flush, i_mdu_res_ready,
        input  o_mdu_ready, o_mdu_valid, o_mdu_result, o_mdu_busy
    );

    modport slave (
        input  i_mdu_valid, i_mdu_op, i_mdu_a, i_mdu_b, i_mdu_flush, i_mdu_res_ready,
        output o_mdu_ready, o_mdu_valid, o_mdu_result, o_mdu_busy
    );
endinterface

// File: rtl/riscv_mdu.sv
// RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, with an optional single-cycle multiplier and fast divide special cases.
module riscv_mdu #(
    parameter int XLEN     = 32,
    parameter bit MUL_FAST = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    riscv_mdu_if.slave  mdu
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_reg;
    logic              ready_reg;
    logic              valid_reg;
    logic              busy_reg;
    logic [XLEN-1:0]   result_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [2:0]        op_reg;
    logic [XLEN-1:0]   opb_reg;
    logic [2*XLEN-1:0] acc_reg;
    logic              neg_reg;
    logic              rem_neg_reg;

    // Request decode, evaluated on the raw inputs so everything latches on the accept edge
    logic [2:0]        op_in;
    logic              a_signed_in;
    logic              b_signed_in;
    logic              sa_in;
    logic              sb_in;
    logic [XLEN-1:0]   mag_a_in;
    logic [XLEN-1:0]   mag_b_in;
    logic              div_zero_in;
    logic              div_ovf_in;
    logic [XLEN-1:0]   special_res_in;
    logic [2*XLEN-1:0] fast_prod;
    logic [2*XLEN-1:0] fast_prod_fix;
    logic [XLEN-1:0]   fast_res_in;

    assign op_in       = mdu.i_mdu_op;
    assign a_signed_in = (op_in == 3'd1) || (op_in == 3'd2) || (op_in == 3'd4) || (op_in == 3'd6);
    assign b_signed_in = (op_in == 3'd1) || (op_in == 3'd4) || (op_in == 3'd6);
    assign sa_in       = a_signed_in & mdu.i_mdu_a[XLEN-1];
    assign sb_in       = b_signed_in & mdu.i_mdu_b[XLEN-1];
    assign mag_a_in    = sa_in ? -mdu.i_mdu_a : mdu.i_mdu_a;
    assign mag_b_in    = sb_in ? -mdu.i_mdu_b : mdu.i_mdu_b;
    assign div_zero_in = op_in[2] && (mdu.i_mdu_b == '0);
    assign div_ovf_in  = ((op_in == 3'd4) || (op_in == 3'd6)) &&
                         (mdu.i_mdu_a == {1'b1, {(XLEN-1){1'b0}}}) && (mdu.i_mdu_b == '1);

    // ops 6/7 are remainders; ops 4/5 quotients
    assign special_res_in = op_in[1] ? (div_zero_in ? mdu.i_mdu_a : '0)
                                     : (div_zero_in ? '1 : mdu.i_mdu_a);

    generate
        if (MUL_FAST) begin : g_fast_mul
            assign fast_prod = {{XLEN{1'b0}}, mag_a_in} * {{XLEN{1'b0}}, mag_b_in};
        end else begin : g_iter_mul
            assign fast_prod = '0;
        end
    endgenerate

    assign fast_prod_fix = (sa_in ^ sb_in) ? -fast_prod : fast_prod;
    assign fast_res_in   = (op_in == 3'd0) ? fast_prod_fix[XLEN-1:0] : fast_prod_fix[2*XLEN-1:XLEN];

    // One radix-2 step. Multiply keeps {partial_hi, multiplier} and shifts right;
    // divide keeps {remainder, dividend/quotient} and shifts left.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;

    assign mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
    assign mul_next  = {mul_sum, acc_reg[XLEN-1:1]};
    assign div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, opb_reg};
    assign div_diff  = div_shift[XLEN-1:0] - opb_reg;
    assign div_next  = {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc_reg[XLEN-2:0], div_ge};
    assign acc_next  = op_reg[2] ? div_next : mul_next;

    assign prod_fix = neg_reg ? -acc_next : acc_next;
    assign quo_fix  = neg_reg ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    assign rem_fix  = rem_neg_reg ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];

    always_comb begin
        final_res = '0;
        case (op_reg)
            3'd0:       final_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       final_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5: final_res = quo_fix;
            default:    final_res = rem_fix;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= IDLE;
            ready_reg  <= 1'b1;
            valid_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            result_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!mdu.i_mdu_flush && mdu.i_mdu_valid && ready_reg) begin
                        op_reg      <= op_in;
                        opb_reg     <= mag_b_in;
                        acc_reg     <= {{XLEN{1'b0}}, mag_a_in};
                        neg_reg     <= sa_in ^ sb_in;
                        rem_neg_reg <= sa_in;
                        ready_reg   <= 1'b0;
                        busy_reg    <= 1'b1;
                        if (div_zero_in || div_ovf_in) begin
                            result_reg <= special_res_in;
                            valid_reg  <= 1'b1;
                            state_reg  <= DONE;
                        end else if (MUL_FAST && !op_in[2]) begin
                            result_reg <= fast_res_in;
                            valid_reg  <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            cnt_reg   <= CNT_W'(XLEN-1);
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (mdu.i_mdu_flush) begin
                        state_reg <= IDLE;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        acc_reg <= acc_next;
                        if (cnt_reg == '0) begin
                            result_reg <= final_res;
                            valid_reg  <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (mdu.i_mdu_flush || mdu.i_mdu_res_ready) begin
                        state_reg <= IDLE;
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mdu.o_mdu_ready  = ready_reg;
    assign mdu.o_mdu_valid  = valid_reg;
    assign mdu.o_mdu_busy   = busy_reg;
    assign mdu.o_mdu_result = result_reg;
endmodule

// File: tb/tb_riscv_mdu.sv
// Self-checking bench: iterative and fast-multiply instances driven in lockstep and
// compared against a plain-arithmetic RV32M reference model.
module tb_riscv_mdu;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_valid = 1'b0;
    logic        m_flush = 1'b0;
    logic        m_res_ready = 1'b0;
    logic [2:0]  m_op = 3'd0;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_b = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_mdu_if #(.XLEN(XLEN)) bus_iter ();
    riscv_mdu_if #(.XLEN(XLEN)) bus_fast ();

    assign bus_iter.i_mdu_valid     = m_valid;
    assign bus_iter.i_mdu_op        = m_op;
    assign bus_iter.i_mdu_a         = m_a;
    assign bus_iter.i_mdu_b         = m_b;
    assign bus_iter.i_mdu_flush     = m_flush;
    assign bus_iter.i_mdu_res_ready = m_res_ready;
    assign bus_fast.i_mdu_valid     = m_valid;
    assign bus_fast.i_mdu_op        = m_op;
    assign bus_fast.i_mdu_a         = m_a;
    assign bus_fast.i_mdu_b         = m_b;
    assign bus_fast.i_mdu_flush     = m_flush;
    assign bus_fast.i_mdu_res_ready = m_res_ready;

    riscv_mdu #(.XLEN(XLEN), .MUL_FAST(1'b0)) dut_iter (.i_clk(clk), .i_rst(rst), .mdu(bus_iter));
    riscv_mdu #(.XLEN(XLEN), .MUL_FAST(1'b1)) dut_fast (.i_clk(clk), .i_rst(rst), .mdu(bus_fast));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 64'sd0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input bit fast);
        if (!op[2]) return fast ? 1 : XLEN + 1;
        if (b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return XLEN + 1;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_ready_i"}, 32'(bus_iter.o_mdu_ready), 32'd1);
        check({tag, "_valid_i"}, 32'(bus_iter.o_mdu_valid), 32'd0);
        check({tag, "_busy_i"},  32'(bus_iter.o_mdu_busy),  32'd0);
        check({tag, "_ready_f"}, 32'(bus_fast.o_mdu_ready), 32'd1);
        check({tag, "_valid_f"}, 32'(bus_fast.o_mdu_valid), 32'd0);
    endtask

    // Called at a negedge with both units idle; returns at a negedge with both idle again.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        logic [31:0] exp;
        int lat_i, lat_f;
        exp = ref_result(op, a, b);
        m_valid = 1'b1; m_op = op; m_a = a; m_b = b; m_res_ready = 1'b0;
        @(posedge clk);
        lat_i = 0;
        lat_f = 0;
        for (int c = 1; c <= 100 && (lat_i == 0 || lat_f == 0); c++) begin
            @(negedge clk);
            if (c == 1) begin
                m_valid = 1'b0; m_op = 3'($urandom); m_a = $urandom; m_b = $urandom;
            end
            if (lat_i == 0 && bus_iter.o_mdu_valid) lat_i = c;
            if (lat_f == 0 && bus_fast.o_mdu_valid) lat_f = c;
        end
        check("lat_iter",   32'(lat_i), 32'(ref_latency(op, a, b, 1'b0)));
        check("lat_fast",   32'(lat_f), 32'(ref_latency(op, a, b, 1'b1)));
        check("res_iter",   bus_iter.o_mdu_result, exp);
        check("res_fast",   bus_fast.o_mdu_result, exp);
        check("busy_done",  32'(bus_iter.o_mdu_busy), 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus_iter.o_mdu_valid), 32'd1);
            check("hold_res",   bus_iter.o_mdu_result, exp);
            check("hold_ready", 32'(bus_iter.o_mdu_ready), 32'd0);
        end
        m_res_ready = 1'b1;
        @(negedge clk);
        m_res_ready = 1'b0;
        check_idle("release");
        $display("txn op=%0d a=%h b=%h exp=%h res=%h/%h lat=%0d/%0d", op, a, b, exp,
                 bus_iter.o_mdu_result, bus_fast.o_mdu_result, lat_i, lat_f);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(5, 0))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    logic [2:0]  dir_op [14] = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd4, 3'd7,
                                  3'd1, 3'd2, 3'd3, 3'd0, 3'd5, 3'd6};
    logic [31:0] dir_a  [14] = '{32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000,
                                  32'h80000000, 32'h12345678, 32'h12345678, 32'h80000000,
                                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'h7FFFFFFF};
    logic [31:0] dir_b  [14] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'd0, 32'd0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'd1, 32'hFFFFFFFD};

    initial begin
        repeat (3) @(negedge clk);
        check("rst_result_i", bus_iter.o_mdu_result, 32'd0);
        check("rst_result_f", bus_fast.o_mdu_result, 32'd0);
        check_idle("rst");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_op(dir_op[i], dir_a[i], dir_b[i], 0);

        // backpressure: result held for 10 cycles in DONE
        run_op(3'd3, 32'hDEADBEEF, 32'h0000F00D, 10);

        // flush while idle must block acceptance
        m_valid = 1'b1; m_flush = 1'b1; m_op = 3'd5; m_a = 32'd50; m_b = 32'd5;
        @(negedge clk);
        m_valid = 1'b0; m_flush = 1'b0;
        check_idle("flush_idle");

        // flush at iteration 10 of an iterative divide
        m_valid = 1'b1; m_op = 3'd5; m_a = 32'd1000; m_b = 32'd3;
        @(posedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            m_valid = 1'b0;
        end
        check("calc_busy", 32'(bus_iter.o_mdu_busy), 32'd1);
        m_flush = 1'b1;
        @(negedge clk);
        m_flush = 1'b0;
        check_idle("flush_calc");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("no_pulse_i", 32'(bus_iter.o_mdu_valid), 32'd0);
            check("no_pulse_f", 32'(bus_fast.o_mdu_valid), 32'd0);
        end
        run_op(3'd5, 32'd9, 32'd3, 0);

        // reset in the middle of an iterative divide
        m_valid = 1'b1; m_op = 3'd4; m_a = 32'hFFFF0000; m_b = 32'd7;
        @(negedge clk);
        m_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_result", bus_iter.o_mdu_result, 32'd0);
        check_idle("midrst");
        run_op(3'd6, 32'hFFFF0000, 32'd7, 0);

        for (int i = 0; i < 40; i++) run_op(3'($urandom), pick_operand(), pick_operand(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
